// File: rtl/dec_ctrl_pipe_pkg.sv
// rtl/dec_ctrl_pipe_pkg.sv - shared decode constants for dec_ctrl_pipe
package dec_ctrl_pipe_pkg;

   localparam int CTRL_BITS = 11;

   // Control-word bit positions, MSB first
   localparam int C_REGWRITE   = 10;
   localparam int C_REGDST_HI  = 9;
   localparam int C_REGDST_LO  = 8;
   localparam int C_ALUSRC     = 7;
   localparam int C_BRANCH     = 6;
   localparam int C_MEMWRITE   = 5;
   localparam int C_MEMTOREG   = 4;
   localparam int C_JUMP       = 3;
   localparam int C_HILO_WRITE = 2;
   localparam int C_HILO_READ  = 1;
   localparam int C_DIV_START  = 0;

   typedef enum logic [1:0] {
      REGDST_RT  = 2'b00,
      REGDST_RD  = 2'b01,
      REGDST_R31 = 2'b10
   } regdst_e;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/dec_ctrl_pipe_ctrl_decode.sv
// rtl/dec_ctrl_pipe_ctrl_decode.sv - combinational MIPS control decoder
module ctrl_decode
   import dec_ctrl_pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_BITS
) (
   input  logic [31:0]       instr,
   output logic [CTRL_W-1:0] ctrl,
   output logic              invalid
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   logic       unused_fields;

   assign op            = instr[31:26];
   assign rt            = instr[20:16];
   assign funct         = instr[5:0];
   assign unused_fields = ^{instr[25:21], instr[15:6]};

   always_comb begin
      ctrl    = '0;
      invalid = 1'b0;
      unique case (op)
         OP_SPECIAL: begin
            unique case (funct)
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                  ctrl[C_REGWRITE]              = 1'b1;
                  ctrl[C_REGDST_HI:C_REGDST_LO] = REGDST_RD;
               end
               FN_MFHI, FN_MFLO: begin
                  ctrl[C_REGWRITE]              = 1'b1;
                  ctrl[C_REGDST_HI:C_REGDST_LO] = REGDST_RD;
                  ctrl[C_HILO_READ]             = 1'b1;
               end
               FN_MULT, FN_MULTU, FN_MTHI, FN_MTLO:
                  ctrl[C_HILO_WRITE] = 1'b1;
               FN_DIV, FN_DIVU: begin
                  ctrl[C_HILO_WRITE] = 1'b1;
                  ctrl[C_DIV_START]  = 1'b1;
               end
               FN_JR:
                  ctrl[C_JUMP] = 1'b1;
               FN_JALR: begin
                  ctrl[C_REGWRITE]              = 1'b1;
                  ctrl[C_REGDST_HI:C_REGDST_LO] = REGDST_RD;
                  ctrl[C_JUMP]                  = 1'b1;
               end
               default: invalid = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            unique case (rt)
               RT_BLTZ, RT_BGEZ:
                  ctrl[C_BRANCH] = 1'b1;
               RT_BLTZAL, RT_BGEZAL: begin
                  ctrl[C_REGWRITE]              = 1'b1;
                  ctrl[C_REGDST_HI:C_REGDST_LO] = REGDST_R31;
                  ctrl[C_BRANCH]                = 1'b1;
               end
               default: invalid = 1'b1;
            endcase
         end
         OP_J:
            ctrl[C_JUMP] = 1'b1;
         OP_JAL: begin
            ctrl[C_REGWRITE]              = 1'b1;
            ctrl[C_REGDST_HI:C_REGDST_LO] = REGDST_R31;
            ctrl[C_JUMP]                  = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
            ctrl[C_BRANCH] = 1'b1;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_ALUSRC]   = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_ALUSRC]   = 1'b1;
            ctrl[C_MEMTOREG] = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            ctrl[C_ALUSRC]   = 1'b1;
            ctrl[C_MEMWRITE] = 1'b1;
         end
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/dec_ctrl_pipe.sv
// rtl/dec_ctrl_pipe.sv - decode buffer FIFO with HI/LO divide interlock
module dec_ctrl_pipe
   import dec_ctrl_pipe_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int DIV_CYCLES = 36,
   parameter int CTRL_W     = CTRL_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [31:0]       pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic              out_invalid,
   output logic              div_busy
);

   localparam int SLOTS = 2;

   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_invalid;

   logic [31:0]       instr_mem [SLOTS];
   logic [31:0]       pc_mem    [SLOTS];
   logic [CTRL_W-1:0] ctrl_mem  [SLOTS];
   logic              inv_mem   [SLOTS];

   logic [1:0] count_q, count_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [5:0] busy_q, busy_d;

   logic [CTRL_W-1:0] head_ctrl;
   logic              head_hilo;
   logic              head_ok;
   logic              push;
   logic              pop;

   function automatic logic ptr_inc(input logic p);
      return (DEPTH == 1) ? 1'b0 : ~p;
   endfunction

   ctrl_decode #(.CTRL_W(CTRL_W)) u_ctrl_decode (
      .instr   (instr),
      .ctrl    (dec_ctrl),
      .invalid (dec_invalid)
   );

   assign head_ctrl = ctrl_mem[rd_ptr_q];
   assign head_hilo = head_ctrl[C_HILO_READ] | head_ctrl[C_HILO_WRITE];
   assign div_busy  = (busy_q != 6'd0);
   // A HI/LO user at the head stalls everything behind it until the divide drains
   assign head_ok   = (count_q != 2'd0) && !(div_busy && head_hilo);

   assign in_ready    = (count_q < 2'(DEPTH));
   assign push        = in_valid && in_ready && !flush;
   assign pop         = head_ok && out_ready && !flush;

   assign out_valid   = head_ok;
   assign out_ctrl    = head_ok ? head_ctrl : '0;
   assign out_invalid = head_ok && inv_mem[rd_ptr_q];
   assign out_instr   = instr_mem[rd_ptr_q];
   assign out_pc      = pc_mem[rd_ptr_q];

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      busy_d   = busy_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      if (pop && head_ctrl[C_DIV_START]) begin
         busy_d = 6'(DIV_CYCLES);
      end else if (busy_q != 6'd0) begin
         busy_d = busy_q - 6'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         busy_q   <= 6'd0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         busy_q   <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= instr;
         pc_mem[wr_ptr_q]    <= pc;
         ctrl_mem[wr_ptr_q]  <= dec_ctrl;
         inv_mem[wr_ptr_q]   <= dec_invalid;
      end
   end

endmodule

// File: tb/tb_dec_ctrl_pipe.sv
// tb/tb_dec_ctrl_pipe.sv - directed self-checking bench for dec_ctrl_pipe
module tb_dec_ctrl_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_ctrl;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_invalid;
   logic        div_busy;

   int n_checks = 0;
   int n_fail   = 0;

   dec_ctrl_pipe #(.DEPTH(2), .DIV_CYCLES(4), .CTRL_W(11)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .pc          (pc),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ctrl    (out_ctrl),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_invalid (out_invalid),
      .div_busy    (div_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
      in_valid = v;
      instr    = ins;
      pc       = p;
   endtask

   localparam logic [31:0] I_ADD   = 32'h012A4020;
   localparam logic [31:0] I_LW    = 32'h8C880004;
   localparam logic [31:0] I_JAL   = 32'h0C000010;
   localparam logic [31:0] I_DIV   = 32'h0109001A;
   localparam logic [31:0] I_MFLO  = 32'h00004012;
   localparam logic [31:0] I_ADDI  = 32'h20010005;
   localparam logic [31:0] I_SW    = 32'hAC010000;
   localparam logic [31:0] I_BEQ   = 32'h10000003;
   localparam logic [31:0] I_RSVD  = 32'hFC000000;

   logic [31:0] tv_instr [9] = '{32'h00000000, 32'h04110004, 32'h03E00008, 32'h03E00011,
                                 32'h3C011234, 32'h04050000, 32'h00000001, 32'h0060F809,
                                 32'h08000100};
   logic [31:0] tv_ctrl  [9] = '{32'h500, 32'h640, 32'h008, 32'h004,
                                 32'h480, 32'h000, 32'h000, 32'h508,
                                 32'h008};
   logic [31:0] tv_inv   [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_div_busy", 32'(div_busy), 0);
      chk("rst_out_ctrl", 32'(out_ctrl), 0);
      chk("rst_out_invalid", 32'(out_invalid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single ADD, visible the cycle after acceptance
      out_ready = 1'b1;
      drive(1'b1, I_ADD, 32'h100);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      chk("add_valid", 32'(out_valid), 1);
      chk("add_ctrl", 32'(out_ctrl), 32'h500);
      chk("add_invalid", 32'(out_invalid), 0);
      chk("add_instr", out_instr, I_ADD);
      chk("add_pc", out_pc, 32'h100);
      tick;
      chk("add_drained", 32'(out_valid), 0);
      chk("add_drained_ctrl", 32'(out_ctrl), 0);

      // LW then JAL back-to-back, second push coincides with first pop
      drive(1'b1, I_LW, 32'h200);
      tick;
      chk("lw_ctrl", 32'(out_ctrl), 32'h490);
      drive(1'b1, I_JAL, 32'h204);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      chk("jal_ctrl", 32'(out_ctrl), 32'h608);
      chk("jal_pc", out_pc, 32'h204);
      chk("jal_in_ready", 32'(in_ready), 1);
      tick;
      chk("lwjal_drained", 32'(out_valid), 0);

      // DIV then MFLO: MFLO held while busy window runs
      out_ready = 1'b0;
      drive(1'b1, I_DIV, 32'h300);
      tick;
      drive(1'b1, I_MFLO, 32'h304);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      chk("div_ctrl", 32'(out_ctrl), 32'h005);
      chk("div_prepop_busy", 32'(div_busy), 0);
      chk("div_full_in_ready", 32'(in_ready), 0);
      out_ready = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mflo_held_valid_%0d", i), 32'(out_valid), 0);
         chk($sformatf("mflo_held_busy_%0d", i), 32'(div_busy), 1);
         chk($sformatf("mflo_held_ctrl_%0d", i), 32'(out_ctrl), 0);
         tick;
      end
      chk("mflo_valid", 32'(out_valid), 1);
      chk("mflo_ctrl", 32'(out_ctrl), 32'h502);
      chk("mflo_busy_clear", 32'(div_busy), 0);
      chk("mflo_pc", out_pc, 32'h304);
      tick;
      chk("mflo_drained", 32'(out_valid), 0);

      // decode table
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, tv_instr[i], 32'h400 + 32'(i * 4));
         tick;
         drive(1'b0, 32'h0, 32'h0);
         chk($sformatf("tbl_valid_%0d", i), 32'(out_valid), 1);
         chk($sformatf("tbl_ctrl_%0d", i), 32'(out_ctrl), tv_ctrl[i]);
         chk($sformatf("tbl_invalid_%0d", i), 32'(out_invalid), tv_inv[i]);
         tick;
      end

      // backpressure: third push waits for an out_ready pulse
      out_ready = 1'b0;
      drive(1'b1, I_ADDI, 32'h500);
      tick;
      drive(1'b1, I_SW, 32'h504);
      tick;
      chk("bp_full", 32'(in_ready), 0);
      drive(1'b1, I_BEQ, 32'h508);
      tick;
      chk("bp_still_full", 32'(in_ready), 0);
      chk("bp_head_addi", 32'(out_ctrl), 32'h480);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("bp_head_sw", 32'(out_ctrl), 32'h0A0);
      chk("bp_head_sw_pc", out_pc, 32'h504);
      chk("bp_room", 32'(in_ready), 1);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      chk("bp_refull", 32'(in_ready), 0);
      chk("bp_hold_sw", out_pc, 32'h504);
      out_ready = 1'b1;
      tick;
      chk("bp_head_beq", 32'(out_ctrl), 32'h040);
      chk("bp_head_beq_pc", out_pc, 32'h508);
      tick;
      chk("bp_drained", 32'(out_valid), 0);

      // reserved opcode, then flush with two entries buffered
      out_ready = 1'b0;
      drive(1'b1, I_RSVD, 32'h600);
      tick;
      chk("rsvd_valid", 32'(out_valid), 1);
      chk("rsvd_invalid", 32'(out_invalid), 1);
      chk("rsvd_ctrl", 32'(out_ctrl), 0);
      drive(1'b1, I_ADD, 32'h604);
      tick;
      chk("flush_pre_full", 32'(in_ready), 0);
      flush     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, I_ADD, 32'h608);
      tick;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_invalid", 32'(out_invalid), 0);
      tick;
      chk("flush_no_push", 32'(out_valid), 0);

      // async reset mid-division with FIFO full
      drive(1'b1, I_DIV, 32'h700);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      tick;
      out_ready = 1'b0;
      drive(1'b1, I_ADD, 32'h704);
      tick;
      drive(1'b1, I_ADD, 32'h708);
      tick;
      drive(1'b0, 32'h0, 32'h0);
      chk("ar_busy", 32'(div_busy), 1);
      chk("ar_full", 32'(in_ready), 0);
      chk("ar_valid", 32'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_busy_clear", 32'(div_busy), 0);
      chk("ar_valid_clear", 32'(out_valid), 0);
      chk("ar_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
